// File: rtl/i2c_pkg.sv
// Shared I2C constants: FSM state codes, quarter/bit limits and bus ACK levels.
// The bus sequence monitor uses the same definitions.
package i2c_pkg;

    // FSM state encoding, kept as plain constants for legacy tools.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_START = 3'd1;
    localparam state_t ST_ADDR  = 3'd2;
    localparam state_t ST_AACK  = 3'd3;
    localparam state_t ST_DATA  = 3'd4;
    localparam state_t ST_DACK  = 3'd5;
    localparam state_t ST_STOP  = 3'd6;

    localparam logic [1:0] Q_LAST   = 2'd3;
    localparam logic [1:0] Q_SAMPLE = 2'd2;
    localparam logic [2:0] BIT_LAST = 3'd7;

    localparam logic ACK_LVL  = 1'b0;
    localparam logic NACK_LVL = 1'b1;

endpackage

// File: rtl/i2c_qtick.sv
// Quarter-bit timebase: divides clk by CLK_DIV and tracks the quarter index q0..q3.
// Held at zero whenever the master is idle or in reset.
module i2c_qtick #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    output logic       tick,
    output logic       first,
    output logic [1:0] qidx
);

    localparam logic [7:0] CNT_LAST = 8'(CLK_DIV - 1);

    logic [7:0] qcnt;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            qcnt <= '0;
            qidx <= '0;
        end else if (qcnt == CNT_LAST) begin
            qcnt <= '0;
            qidx <= qidx + 2'd1;
        end else begin
            qcnt <= qcnt + 8'd1;
        end
    end

    assign tick  = run && (qcnt == CNT_LAST);
    assign first = run && (qcnt == 8'd0);

endmodule

// File: rtl/i2c_byte_master.sv
// Single-byte I2C master: START, address+R/W, ACK, one data byte, ACK, STOP.
// Bus outputs are registered from next-state values so edges land on quarter boundaries.
module i2c_byte_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    input  logic       sda_i,
    output logic       scl_o,
    output logic       sda_o,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata
);

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_n;
    logic [1:0] qidx, q_n;
    logic       tick, first;
    logic [6:0] addr_q;
    logic       rw_q;
    logic [7:0] wdata_q, rx_sh, tx_byte;
    logic       scl_n, sda_n, oe_n, slot_scl;
    logic       accept, sample_pt, sample_ack, sample_rd, nack, finish;

    i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
        .clk   (clk),
        .reset (reset),
        .run   (state != ST_IDLE),
        .tick  (tick),
        .first (first),
        .qidx  (qidx)
    );

    assign accept     = (state == ST_IDLE) && !busy && start;
    assign sample_pt  = first && (qidx == Q_SAMPLE);
    assign sample_ack = sample_pt && ((state == ST_AACK) || ((state == ST_DACK) && !rw_q));
    assign sample_rd  = sample_pt && (state == ST_DATA) && rw_q;
    assign nack       = (sda_i !== ACK_LVL);
    assign finish     = tick && (qidx == Q_LAST) && (state == ST_STOP);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n = state;
        bit_n   = bit_cnt;
        q_n     = qidx;
        if (accept) begin
            state_n = ST_START;
            bit_n   = '0;
            q_n     = '0;
        end else if (tick) begin
            q_n = qidx + 2'd1;
            if (qidx == Q_LAST) begin
                case (state)
                    ST_START: begin
                        state_n = ST_ADDR;
                        bit_n   = '0;
                    end
                    ST_ADDR: begin
                        bit_n = bit_cnt + 3'd1;
                        if (bit_cnt == BIT_LAST) state_n = ST_AACK;
                    end
                    ST_AACK: state_n = ack_err ? ST_STOP : ST_DATA;
                    ST_DATA: begin
                        bit_n = bit_cnt + 3'd1;
                        if (bit_cnt == BIT_LAST) state_n = ST_DACK;
                    end
                    ST_DACK: state_n = ST_STOP;
                    default: state_n = ST_IDLE;
                endcase
            end
        end
    end

    // Output levels for the quarter about to begin.
    always_comb begin
        tx_byte  = (state_n == ST_ADDR) ? {addr_q, rw_q} : wdata_q;
        slot_scl = (q_n == 2'd1) || (q_n == 2'd2);
        scl_n    = 1'b1;
        oe_n     = 1'b0;
        sda_n    = NACK_LVL;
        case (state_n)
            ST_START: begin
                oe_n  = 1'b1;
                sda_n = (q_n == 2'd0);
                scl_n = (q_n != Q_LAST);
            end
            ST_ADDR: begin
                scl_n = slot_scl;
                oe_n  = 1'b1;
                sda_n = tx_byte[BIT_LAST - bit_n];
            end
            ST_DATA: begin
                scl_n = slot_scl;
                oe_n  = !rw_q;
                if (!rw_q) sda_n = tx_byte[BIT_LAST - bit_n];
            end
            ST_AACK, ST_DACK: scl_n = slot_scl;
            ST_STOP: begin
                scl_n = (q_n != 2'd0);
                oe_n  = (q_n <= 2'd1);
                if (q_n <= 2'd1) sda_n = 1'b0;
            end
            default: ;
        endcase
    end

    // NOTE: the request latches are reset along with control so nothing reads X after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            scl_o   <= 1'b1;
            sda_o   <= 1'b1;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
            rdata   <= '0;
            rx_sh   <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_n;
            scl_o   <= scl_n;
            sda_o   <= sda_n;
            sda_oe  <= oe_n;
            done    <= finish;
            if (accept) begin
                busy    <= 1'b1;
                ack_err <= 1'b0;
                addr_q  <= addr;
                rw_q    <= rw;
                wdata_q <= wdata;
            end else begin
                if (done) busy <= 1'b0;
                if (sample_ack && nack) ack_err <= 1'b1;
            end
            if (sample_rd) rx_sh <= {rx_sh[6:0], sda_i};
            // An address NACK on a read leaves the previous read byte in place.
            if (finish && rw_q && !ack_err) rdata <= rx_sh;
        end
    end

endmodule

// File: doc/i2c_byte_master.md
# i2c_byte_master

Transmit-side companion to the I2C bus sequence monitor. It generates one complete I2C transaction on `scl`/`sda`: START, a 7-bit address plus R/W, an ACK slot, one data byte (written or read), an ACK slot, then STOP. It sits between a register-level request interface and the open-drain pad wrappers. Its bus output is the stimulus source for the monitor FSM.

## Interface
- `CLK_DIV`, default 4: system clocks per quarter SCL bit period (Q). Legal range is 2..255.
- `clk` in 1: system clock. All logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request pulse. It is sampled only in IDLE.
- `addr` in 7: target address. Latched when `start` is accepted.
- `rw` in 1: 0 = write `wdata`, 1 = read into `rdata`. Latched when `start` is accepted.
- `wdata` in 8: write byte. Latched when `start` is accepted.
- `sda_i` in 1: sampled bus SDA.
- `scl_o` out 1: SCL level. 1 = released.
- `sda_o` out 1: SDA drive level. Meaningful only when `sda_oe` = 1.
- `sda_oe` out 1: 1 = drive `sda_o`; 0 = release SDA.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse at the end of STOP.
- `ack_err` out 1: NACK seen. Valid with `done`; held until the next accepted `start`.
- `rdata` out 8: read byte. Valid with `done` when `rw` = 1; held until the next read completes.

## Operation
- States: IDLE → START → ADDR (8 bit slots) → AACK → DATA (8 bit slots) → DACK → STOP → IDLE.
- A NACK in AACK jumps straight to STOP.
- Every state except IDLE lasts 4 quarters, q0..q3, and each quarter is CLK_DIV clocks. Each bit slot is also 4 quarters.
- IDLE: `scl_o`=1, `sda_oe`=0.
- START: SDA is driven as follows.
  - q0: `sda_o`=1, `scl_o`=1.
  - q1 and q2: `sda_o`=0, `scl_o`=1.
  - q3: `sda_o`=0, `scl_o`=0.
- Bit slot:
  - q0: `scl_o`=0; SDA is set to the bit value.
  - q1 and q2: `scl_o`=1.
  - q3: `scl_o`=0.
  - SDA is stable for the whole slot.
- Bit order: ADDR sends {addr, rw}, MSB first. DATA write sends `wdata`, MSB first.
- DATA read: `sda_oe`=0. `sda_i` is sampled on the first clock of q2 and shifted in MSB first.
- AACK, and DACK on a write: `sda_oe`=0; `sda_i` is sampled on the first clock of q2.
  - `sda_i`=0 is an ACK.
  - `sda_i`=1 sets `ack_err`.
- DACK on a read: the master sends NACK, i.e. `sda_oe`=0.
- STOP:
  - q0: `scl_o`=0, `sda_o`=0.
  - q1: `scl_o`=1, `sda_o`=0.
  - q2 and q3: `scl_o`=1, `sda_oe`=0.
  - Then `done`=1 for one cycle and the block returns to IDLE.
- A data NACK still completes the transaction normally (DATA, DACK, STOP).
- `start` while busy is ignored and not queued.
- Reset in any state:
  - On the next edge: IDLE, `scl_o`=1, `sda_oe`=0, `sda_o`=1, `busy`=0, `done`=0, `ack_err`=0, `rdata`=0.
  - No STOP is emitted.
- `start` in the same cycle as `reset` is ignored.
- `sda_i` X during a sample counts as NACK.

## Timing
- Accept: `start` is sampled high at edge E0. State is START and `busy`=1 after E0, and the q0 of START begins that cycle.
- Full transaction: 4 + 72 + 4 = 80 Q. `done` is high in cycle E0 + 80·CLK_DIV.
- Address NACK: 4 + 36 + 4 = 44 Q. `done` is high at E0 + 44·CLK_DIV.
- `busy` falls in the cycle after `done`. A new `start` is accepted in that same cycle.
- Outputs are registered, so bus edges are aligned exactly to quarter boundaries.
- Quarter counter is 8 bits wide and counts 0..CLK_DIV-1.
- Quarter index is 2 bits wide; bit index is 3 bits wide.
- The quarter counter is held at 0 in IDLE.

## Structure
- Shared package `i2c_pkg` holds:
  - the state enum;
  - quarter and bit-count constants;
  - the ACK/NACK level constants, so they are shared with the monitor.
- One sub-module, `i2c_qtick`:
  - CLK_DIV divider;
  - emits a one-cycle quarter tick plus the 2-bit quarter index;
  - cleared by `reset` or idle.
- The top level holds the FSM, shift registers and output registers.

## Test plan
- Write with ACK: CLK_DIV=4, addr=7'h50, rw=0, wdata=8'hA5, `sda_i` tied 0 in ACK slots.
  - SDA bits in ADDR = 1010_0000; SDA bits in DATA = 1010_0101.
  - `done` at E0+320; `ack_err`=0.
- Address NACK: `sda_i`=1 during AACK.
  - STOP immediately, `done` at E0+176, `ack_err`=1.
  - No DATA clocks occur (exactly 9 SCL pulses after START).
- Read: addr=7'h3C, rw=1; the responder drives 8'h96 in the DATA slots.
  - `rdata`=8'h96 at `done`; master releases SDA in DACK; `done` at E0+320.
- Start while busy: `start` is pulsed at E0+50.
  - Ignored; a single transaction occurs.
  - Back-to-back `start` in the cycle after `done` is accepted.
- Reset mid-DATA: `reset` at E0+200.
  - Next cycle: `scl_o`=1, `sda_oe`=0, `busy`=0, `done`=0.
  - No STOP pattern; the next `start` runs a full transaction.
- Monitor cross-check: drive this block into the bus sequence monitor with CLK_DIV=2.
  - START/STOP conditions: SDA changes only while SCL=1.
  - All data changes occur only while SCL=0.
